// File: rtl/dfe_pkg.sv
// dfe_pkg: arbiter FSM state encoding, default widths
// and a small index-width helper shared by the hash port logic.
package dfe_pkg;

  localparam int DEF_NUM_PROCESSOR = 3;
  localparam int DEF_BIT_ON_TAILS  = 7;
  localparam int DEF_COUNT_WIDTH   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LAT   = 3'd2,
    S_WR    = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching
// upward from the slot after last_grant.
module rr_arbiter
  import dfe_pkg::*;
#(
  parameter int N  = DEF_NUM_PROCESSOR,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last_grant,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [PW-1:0] k;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = PW'((int'(last_grant) + i) % N);
      if (!valid && req[k]) begin
        pick[k] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_port_arbiter.sv
// hash_port_arbiter: shares one BRAM port among hash-build
// processors doing read-increment-write, plus a table clear sweep.
module hash_port_arbiter
  import dfe_pkg::*;
#(
  parameter int NUM_PROCESSOR = DEF_NUM_PROCESSOR,
  parameter int BIT_ON_TAILS  = DEF_BIT_ON_TAILS,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PROCESSOR-1:0]              req,
  input  logic [NUM_PROCESSOR*BIT_ON_TAILS-1:0] req_addr,
  input  logic                                  clear,
  output logic [NUM_PROCESSOR-1:0]              gnt,
  output logic [NUM_PROCESSOR-1:0]              done,
  output logic [COUNT_WIDTH-1:0]                rd_count,
  output logic [BIT_ON_TAILS-1:0]               mem_addr,
  output logic                                  mem_we,
  output logic [COUNT_WIDTH-1:0]                mem_wdata,
  input  logic [COUNT_WIDTH-1:0]                mem_rdata,
  output logic                                  busy,
  output logic                                  clr_busy
);

  localparam int NP = NUM_PROCESSOR;
  localparam int AW = BIT_ON_TAILS;
  localparam int CW = COUNT_WIDTH;
  localparam int PW = idx_w(NP);
  localparam logic [PW-1:0] LAST_RST = PW'(NP - 1);

  state_t        state_q;
  logic [PW-1:0] last_q;
  logic [PW-1:0] owner_q;
  logic [NP-1:0] own_oh_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;
  logic          clr_pend_q;

  logic [NP-1:0] gnt_q;
  logic [NP-1:0] done_q;
  logic [CW-1:0] rd_count_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [CW-1:0] mem_wdata_q;
  logic          busy_q;
  logic          clr_busy_q;

  logic [NP-1:0] pick;
  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic [AW-1:0] pick_addr;
  logic [CW-1:0] wdata_d;

  rr_arbiter #(
    .N  (NP),
    .PW (PW)
  ) u_rr (
    .req        (req),
    .last_grant (last_q),
    .pick       (pick),
    .valid      (pick_vld)
  );

  always_comb begin
    pick_idx  = '0;
    pick_addr = '0;
    for (int i = 0; i < NP; i++) begin
      if (pick[i]) begin
        pick_idx  = PW'(i);
        pick_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // counter sticks at all-ones instead of wrapping
  assign wdata_d = (&mem_rdata) ? mem_rdata
                                : mem_rdata + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= LAST_RST;
      owner_q     <= '0;
      own_oh_q    <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      clr_pend_q  <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      rd_count_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      clr_busy_q  <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      if (clear && (state_q == S_RD ||
                    state_q == S_LAT ||
                    state_q == S_WR)) begin
        clr_pend_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (clear || clr_pend_q) begin
            state_q     <= S_CLEAR;
            clr_pend_q  <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= '0;
            busy_q      <= 1'b1;
            clr_busy_q  <= 1'b1;
          end else if (pick_vld) begin
            state_q    <= S_RD;
            owner_q    <= pick_idx;
            own_oh_q   <= pick;
            addr_q     <= pick_addr;
            gnt_q      <= pick;
            mem_addr_q <= pick_addr;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RD: begin
          state_q <= S_LAT;
        end
        S_LAT: begin
          state_q     <= S_WR;
          mem_addr_q  <= addr_q;
          mem_we_q    <= 1'b1;
          mem_wdata_q <= wdata_d;
          rd_count_q  <= wdata_d;
          done_q      <= own_oh_q;
        end
        S_WR: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          last_q   <= owner_q;
        end
        S_CLEAR: begin
          if (&cnt_q) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            clr_busy_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + AW'(1);
            mem_addr_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rd_count  = rd_count_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign clr_busy  = clr_busy_q;

endmodule

// File: tb/tb_hash_port_arbiter.sv
// tb_hash_port_arbiter: directed scenarios plus random
// contention checked against a transaction-level model.
module tb_hash_port_arbiter;

  localparam int NP = 3;
  localparam int B  = 7;
  localparam int CW = 16;
  localparam int D  = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req;
  logic [NP*B-1:0] req_addr;
  logic          clear;
  logic [NP-1:0] gnt;
  logic [NP-1:0] done;
  logic [CW-1:0] rd_count;
  logic [B-1:0]  mem_addr;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;
  logic          busy;
  logic          clr_busy;

  logic [CW-1:0] mem [D];
  logic [CW-1:0] ref_mem [D];

  int n_chk = 0;
  int n_pass = 0;

  int cyc, owner_m, last_m, free_cyc, gnt_cyc;
  int addr_m;

  always #5 clk = ~clk;

  hash_port_arbiter #(
    .NUM_PROCESSOR (NP),
    .BIT_ON_TAILS  (B),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .clear     (clear),
    .gnt       (gnt),
    .done      (done),
    .rd_count  (rd_count),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .clr_busy  (clr_busy)
  );

  // BRAM with one cycle read latency
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    int s;
    s = int'(v) + 1;
    return (s > (1 << CW) - 1) ? v : CW'(s);
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] r,
                                 input int last);
    for (int i = 1; i <= NP; i++) begin
      int k;
      k = (last + i) % NP;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_addr(input int p, input int a);
    req_addr[p*B +: B] = B'(a);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input string tag, input int p,
                        input int a, input logic [CW-1:0] pre);
    logic [NP-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    mem[a] = pre;
    set_addr(p, a);
    req = oh;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    check({tag, "_rdaddr"}, 32'(mem_addr), a);
    check({tag, "_rdwe"}, 32'(mem_we), 0);
    @(negedge clk);
    check({tag, "_latwe"}, 32'(mem_we), 0);
    check({tag, "_latdone"}, 32'(done), 0);
    @(negedge clk);
    check({tag, "_we"}, 32'(mem_we), 1);
    check({tag, "_waddr"}, 32'(mem_addr), a);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'(sat_inc(pre)));
    check({tag, "_done"}, 32'(done), 32'(oh));
    check({tag, "_cnt"}, 32'(rd_count), 32'(sat_inc(pre)));
    req = '0;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, mem_we}, 0);
    check({tag, "_mem"}, 32'(mem[a]), 32'(sat_inc(pre)));
  endtask

  task automatic rnd_step(input bit raise);
    int e;
    logic [CW-1:0] v;
    logic [NP-1:0] oh;
    @(negedge clk);
    cyc++;
    if (owner_m < 0 && cyc >= free_cyc && req != '0)
      check("rnd_grant_due", 32'(gnt != '0), 1);
    if (gnt != '0) begin
      check("rnd_idle", 32'(owner_m < 0), 1);
      e = rr_pick(req, last_m);
      check("rnd_gnt", 32'(gnt), (e >= 0) ? (32'd1 << e) : 32'd0);
      if (e >= 0) begin
        owner_m = e;
        addr_m  = int'(req_addr[e*B +: B]);
        last_m  = e;
      end
      gnt_cyc = cyc;
    end
    if (done != '0) begin
      if (owner_m < 0) begin
        check("rnd_spurious_done", 32'(done), 0);
      end else begin
        oh = '0;
        oh[owner_m] = 1'b1;
        check("rnd_done", 32'(done), 32'(oh));
        check("rnd_lat", cyc - gnt_cyc, 2);
        v = sat_inc(ref_mem[addr_m]);
        check("rnd_cnt", 32'(rd_count), 32'(v));
        ref_mem[addr_m] = v;
        req[owner_m] = 1'b0;
        owner_m = -1;
        free_cyc = cyc + 2;
      end
    end else if (owner_m >= 0 && cyc > gnt_cyc + 2) begin
      check("rnd_done_due", 0, 1);
      req[owner_m] = 1'b0;
      owner_m = -1;
      free_cyc = cyc + 4;
    end
    if (raise) begin
      for (int k = 0; k < NP; k++) begin
        if (!req[k] && $urandom_range(0, 2) == 0) begin
          set_addr(k, int'($urandom_range(0, 15)));
          req[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int gl[$];
    int dl[$];
    int nclr, bad, gw, we_seen, dr, mm;

    rst = 1'b1;
    req = '0;
    clear = 1'b0;
    req_addr = '0;
    for (int i = 0; i < D; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", {30'd0, busy, clr_busy}, 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_cnt", 32'(rd_count), 0);
    rst = 1'b0;

    run_op("single", 0, 5, 16'd7);
    run_op("sat", 1, 9, 16'hFFFF);

    // contention from reset: 0,1,2,0
    do_reset();
    set_addr(0, 10);
    set_addr(1, 11);
    set_addr(2, 12);
    req = 3'b111;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (gnt != '0) gl.push_back(int'(gnt));
      if (done != '0) dl.push_back(c);
    end
    req = '0;
    check("cont_ngnt", gl.size(), 4);
    check("cont_g0", (gl.size() > 0) ? gl[0] : -1, 1);
    check("cont_g1", (gl.size() > 1) ? gl[1] : -1, 2);
    check("cont_g2", (gl.size() > 2) ? gl[2] : -1, 4);
    check("cont_g3", (gl.size() > 3) ? gl[3] : -1, 1);
    check("cont_ndone", dl.size(), 3);
    check("cont_d0", (dl.size() > 0) ? dl[0] : -1, 3);
    check("cont_sp1", (dl.size() > 1) ? dl[1] - dl[0] : -1, 4);
    check("cont_sp2", (dl.size() > 2) ? dl[2] - dl[1] : -1, 4);
    wait_idle();

    // request dropped right after grant
    mem[20] = 16'd3;
    set_addr(2, 20);
    req = 3'b100;
    @(negedge clk);
    check("drop_gnt", 32'(gnt), 32'b100);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("drop_done", 32'(done), 32'b100);
    check("drop_cnt", 32'(rd_count), 4);
    @(negedge clk);
    check("drop_idle", 32'(busy), 0);

    // clear beats a simultaneous request
    mem[30] = 16'd55;
    set_addr(1, 30);
    req = 3'b010;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_nogrant", 32'(gnt), 0);
    nclr = 0;
    bad = 0;
    while (clr_busy && nclr < 200) begin
      if (!mem_we || mem_wdata != '0 || mem_addr != B'(nclr)) bad++;
      nclr++;
      @(negedge clk);
    end
    check("clr_len", nclr, 128);
    check("clr_bad", bad, 0);
    gw = 0;
    while (gnt == '0 && gw < 10) begin
      @(negedge clk);
      gw++;
    end
    check("clr_gnt", 32'(gnt), 32'b010);
    check("clr_gnt_lat", gw, 1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("clr_done", 32'(done), 32'b010);
    check("clr_cnt", 32'(rd_count), 1);
    wait_idle();

    // clear arriving mid-op runs before the next request
    mem[50] = 16'd0;
    set_addr(2, 50);
    req = 3'b100;
    @(negedge clk);
    check("pend_gnt", 32'(gnt), 32'b100);
    clear = 1'b1;
    set_addr(0, 51);
    req = 3'b101;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("pend_done", 32'(done), 32'b100);
    req = 3'b001;
    @(negedge clk);
    @(negedge clk);
    check("pend_clr", 32'(clr_busy), 1);
    check("pend_nogrant", 32'(gnt), 0);
    gw = 0;
    while (gnt == '0 && gw < 200) begin
      @(negedge clk);
      gw++;
    end
    check("pend_gnt2", 32'(gnt), 32'b001);
    check("pend_gnt2_lat", gw, 129);
    req = '0;
    wait_idle();

    // reset during LAT
    mem[40] = 16'd9;
    set_addr(0, 40);
    req = 3'b001;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'b001);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    check("abort_outs", {26'd0, gnt, done}, 0);
    check("abort_flags", {30'd0, busy, clr_busy}, 0);
    check("abort_mem", {15'd0, mem_we, mem_addr, 9'd0}, 0);
    check("abort_data", {mem_wdata, rd_count}, 0);
    we_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mem_we) we_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    check("abort_nowe", we_seen, 0);
    check("abort_memval", 32'(mem[40]), 9);
    set_addr(1, 41);
    req = 3'b011;
    @(negedge clk);
    check("abort_next", 32'(gnt), 32'b001);
    req = '0;
    wait_idle();

    // random contention against the model
    do_reset();
    for (int i = 0; i < D; i++) ref_mem[i] = mem[i];
    cyc = 0;
    owner_m = -1;
    last_m = NP - 1;
    free_cyc = 0;
    gnt_cyc = 0;
    addr_m = 0;
    for (int it = 0; it < 700; it++) rnd_step(1'b1);
    dr = 0;
    while ((req != '0 || owner_m >= 0) && dr < 60) begin
      rnd_step(1'b0);
      dr++;
    end
    check("rnd_drain", 32'(req != '0 || owner_m >= 0), 0);
    repeat (2) @(negedge clk);
    mm = 0;
    for (int i = 0; i < D; i++) if (mem[i] !== ref_mem[i]) mm++;
    check("rnd_mem", mm, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
